// File: rtl/ula_pkg.sv
// Shared widths, opcode constants and the flag bundle type for the REDUX-V ALU.
package ula_pkg;

    localparam int BITS = 8;
    localparam int OP   = 8;

    localparam logic [OP-1:0] OP_NOT = 8'd0;
    localparam logic [OP-1:0] OP_AND = 8'd1;
    localparam logic [OP-1:0] OP_OR  = 8'd2;
    localparam logic [OP-1:0] OP_XOR = 8'd3;
    localparam logic [OP-1:0] OP_ADD = 8'd4;
    localparam logic [OP-1:0] OP_SUB = 8'd5;
    localparam logic [OP-1:0] OP_SHL = 8'd6;
    localparam logic [OP-1:0] OP_SHR = 8'd7;

    typedef struct packed {
        logic [BITS-1:0] result;
        logic            zero;
        logic            neg;
        logic            carry;
    } ula_flags_t;

endpackage

// File: rtl/ula_flags_reg.sv
// Synchronous-reset register holding the ALU result and its zero/neg/carry flags.
module ula_flags_reg
    import ula_pkg::*;
(
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic [BITS-1:0] result_d,
    input  logic            zero_d,
    input  logic            neg_d,
    input  logic            carry_d,
    output logic [BITS-1:0] result_q_out,
    output logic            zero_q_out,
    output logic            neg_q_out,
    output logic            carry_q_out
);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            result_q_out <= '0;
            zero_q_out   <= 1'b0;
            neg_q_out    <= 1'b0;
            carry_q_out  <= 1'b0;
        end else begin
            result_q_out <= result_d;
            zero_q_out   <= zero_d;
            neg_q_out    <= neg_d;
            carry_q_out  <= carry_d;
        end
    end

endmodule

// File: rtl/ula.sv
// 8-bit ALU: combinational result from a_in/b_in/op_in, plus a registered
// copy of the result and status flags for the control unit.
module ula
    import ula_pkg::*;
(
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic [BITS-1:0] a_in,
    input  logic [BITS-1:0] b_in,
    input  logic [OP-1:0]   op_in,
    output logic [BITS-1:0] result_out,
    output logic [BITS-1:0] result_q_out,
    output logic            zero_q_out,
    output logic            neg_q_out,
    output logic            carry_q_out
);

    logic [BITS:0] sum;
    logic [BITS:0] diff;
    ula_flags_t    flags;

    // The extra MSB is the ADD carry-out, and for SUB the borrow (set when a < b).
    assign sum  = {1'b0, a_in} + {1'b0, b_in};
    assign diff = {1'b0, a_in} - {1'b0, b_in};

    always_comb begin
        flags.result = '0;
        flags.carry  = 1'b0;
        case (op_in)
            OP_NOT: flags.result = ~b_in;
            OP_AND: flags.result = a_in & b_in;
            OP_OR:  flags.result = a_in | b_in;
            OP_XOR: flags.result = a_in ^ b_in;
            OP_ADD: begin
                flags.result = sum[BITS-1:0];
                flags.carry  = sum[BITS];
            end
            OP_SUB: begin
                flags.result = diff[BITS-1:0];
                flags.carry  = diff[BITS];
            end
            // A logical shift by the full b_in already yields zero once the amount reaches BITS.
            OP_SHL: flags.result = a_in << b_in;
            OP_SHR: flags.result = a_in >> b_in;
            default: begin
                flags.result = '0;
                flags.carry  = 1'b0;
            end
        endcase
        flags.zero = (flags.result == '0);
        flags.neg  = flags.result[BITS-1];
    end

    assign result_out = flags.result;

    ula_flags_reg u_flags_reg (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .result_d     (flags.result),
        .zero_d       (flags.zero),
        .neg_d        (flags.neg),
        .carry_d      (flags.carry),
        .result_q_out (result_q_out),
        .zero_q_out   (zero_q_out),
        .neg_q_out    (neg_q_out),
        .carry_q_out  (carry_q_out)
    );

endmodule

// File: tb/tb_ula.sv
// Bench for ula: directed vector table, reset sequences and random ops
// against an arithmetic reference model.
module tb_ula;

    logic       clk_in;
    logic       rst_in;
    logic [7:0] a_in;
    logic [7:0] b_in;
    logic [7:0] op_in;
    logic [7:0] result_out;
    logic [7:0] result_q_out;
    logic       zero_q_out;
    logic       neg_q_out;
    logic       carry_q_out;

    int pass_cnt;
    int total_cnt;

    // {result[7:0], zero, neg, carry} expected at the next rising edge
    logic [10:0] exp_q[$];

    typedef struct {
        string      name;
        logic [7:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic       carry;
    } vec_t;

    vec_t vecs[$];

    ula dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .a_in         (a_in),
        .b_in         (b_in),
        .op_in        (op_in),
        .result_out   (result_out),
        .result_q_out (result_q_out),
        .zero_q_out   (zero_q_out),
        .neg_q_out    (neg_q_out),
        .carry_q_out  (carry_q_out)
    );

    // clock / reset block
    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic add_vec(input string name, input logic [7:0] op, input logic [7:0] a,
                           input logic [7:0] b, input logic [7:0] res, input logic carry);
        vec_t v;
        v.name = name; v.op = op; v.a = a; v.b = b; v.res = res; v.carry = carry;
        vecs.push_back(v);
    endtask

    // Reference model: plain integer arithmetic over the opcode rules.
    function automatic void model(input int op, input int a, input int b,
                                  output int res, output int carry);
        res = 0;
        carry = 0;
        case (op)
            0: res = 255 - b;
            1: res = a & b;
            2: res = a | b;
            3: res = a ^ b;
            4: begin res = (a + b) % 256; carry = (a + b > 255) ? 1 : 0; end
            5: begin res = (a - b + 256) % 256; carry = (a < b) ? 1 : 0; end
            6: res = (b >= 8) ? 0 : (a * (1 << b)) % 256;
            7: res = (b >= 8) ? 0 : a / (1 << b);
            default: begin res = 0; carry = 0; end
        endcase
    endfunction

    // driver: apply at falling edge, check comb output, queue registered expectation
    task automatic drive(input string name, input logic [7:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] res, input logic carry);
        logic [10:0] e;
        @(negedge clk_in);
        op_in = op; a_in = a; b_in = b;
        #1;
        check({name, " result"}, 32'(result_out), 32'(res));
        exp_q.push_back({res, (res == 8'h00), res[7], carry});
        @(posedge clk_in);
        #1;
        e = exp_q.pop_front();
        check({name, " result_q"}, 32'(result_q_out), 32'(e[10:3]));
        check({name, " zero_q"},   32'(zero_q_out),   32'(e[2]));
        check({name, " neg_q"},    32'(neg_q_out),    32'(e[1]));
        check({name, " carry_q"},  32'(carry_q_out),  32'(e[0]));
    endtask

    task automatic check_q_cleared(input string name);
        check({name, " result_q"}, 32'(result_q_out), 32'h0);
        check({name, " zero_q"},   32'(zero_q_out),   32'h0);
        check({name, " neg_q"},    32'(neg_q_out),    32'h0);
        check({name, " carry_q"},  32'(carry_q_out),  32'h0);
    endtask

    initial begin
        int r, c;
        logic [7:0] ra, rb, rop;
        pass_cnt = 0;
        total_cnt = 0;

        add_vec("not00", 8'd0, 8'hFF, 8'h00, 8'hFF, 1'b0);
        add_vec("notff", 8'd0, 8'hFF, 8'hFF, 8'h00, 1'b0);
        add_vec("not55", 8'd0, 8'hFF, 8'h55, 8'hAA, 1'b0);
        add_vec("and00_00", 8'd1, 8'h00, 8'h00, 8'h00, 1'b0);
        add_vec("and00_ff", 8'd1, 8'h00, 8'hFF, 8'h00, 1'b0);
        add_vec("andff_00", 8'd1, 8'hFF, 8'h00, 8'h00, 1'b0);
        add_vec("andff_ff", 8'd1, 8'hFF, 8'hFF, 8'hFF, 1'b0);
        add_vec("or00_00", 8'd2, 8'h00, 8'h00, 8'h00, 1'b0);
        add_vec("or00_ff", 8'd2, 8'h00, 8'hFF, 8'hFF, 1'b0);
        add_vec("orff_00", 8'd2, 8'hFF, 8'h00, 8'hFF, 1'b0);
        add_vec("orff_ff", 8'd2, 8'hFF, 8'hFF, 8'hFF, 1'b0);
        add_vec("xor00_00", 8'd3, 8'h00, 8'h00, 8'h00, 1'b0);
        add_vec("xor00_ff", 8'd3, 8'h00, 8'hFF, 8'hFF, 1'b0);
        add_vec("xorff_00", 8'd3, 8'hFF, 8'h00, 8'hFF, 1'b0);
        add_vec("xorff_ff", 8'd3, 8'hFF, 8'hFF, 8'h00, 1'b0);
        add_vec("xor09_01", 8'd3, 8'h09, 8'h01, 8'h08, 1'b0);
        add_vec("add0_0", 8'd4, 8'd0, 8'd0, 8'd0, 1'b0);
        add_vec("add0_255", 8'd4, 8'd0, 8'd255, 8'd255, 1'b0);
        add_vec("add255_255", 8'd4, 8'd255, 8'd255, 8'd254, 1'b1);
        add_vec("add255_1", 8'd4, 8'd255, 8'd1, 8'd0, 1'b1);
        add_vec("sub0_1", 8'd5, 8'd0, 8'd1, 8'd255, 1'b1);
        add_vec("sub255_254", 8'd5, 8'd255, 8'd254, 8'd1, 1'b0);
        add_vec("sub254_255", 8'd5, 8'd254, 8'd255, 8'd255, 1'b1);
        add_vec("sub253_255", 8'd5, 8'd253, 8'd255, 8'd254, 1'b1);
        add_vec("shl_ff_2", 8'd6, 8'hFF, 8'd2, 8'hFC, 1'b0);
        add_vec("shr_ff_2", 8'd7, 8'hFF, 8'd2, 8'h3F, 1'b0);
        add_vec("shl_amt0", 8'd6, 8'hA5, 8'd0, 8'hA5, 1'b0);
        add_vec("shr_amt0", 8'd7, 8'hA5, 8'd0, 8'hA5, 1'b0);
        add_vec("shl_01_255", 8'd6, 8'h01, 8'd255, 8'h00, 1'b0);
        add_vec("shl_ff_255", 8'd6, 8'hFF, 8'd255, 8'h00, 1'b0);
        add_vec("shr_01_255", 8'd7, 8'h01, 8'd255, 8'h00, 1'b0);
        add_vec("shr_ff_255", 8'd7, 8'hFF, 8'd255, 8'h00, 1'b0);
        add_vec("shl_80_8", 8'd6, 8'h80, 8'd8, 8'h00, 1'b0);
        add_vec("shr_80_7", 8'd7, 8'h80, 8'd7, 8'h01, 1'b0);
        add_vec("rsv8_ffff", 8'd8, 8'hFF, 8'hFF, 8'h00, 1'b0);
        add_vec("rsv8_ff01", 8'd8, 8'hFF, 8'h01, 8'h00, 1'b0);
        add_vec("rsv200", 8'd200, 8'h7E, 8'h81, 8'h00, 1'b0);

        // reset held for two clocks with live inputs
        rst_in = 1'b1;
        op_in = 8'd2; a_in = 8'h0F; b_in = 8'hF0;
        repeat (2) @(posedge clk_in);
        #1;
        check_q_cleared("reset");
        check("reset comb result", 32'(result_out), 32'hFF);

        @(negedge clk_in);
        rst_in = 1'b0;
        drive("post_reset_add255_1", 8'd4, 8'd255, 8'd1, 8'd0, 1'b1);

        foreach (vecs[i])
            drive(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].carry);

        // reset asserted mid-stream after a nonzero, negative result
        drive("pre_midreset_or", 8'd2, 8'h80, 8'h01, 8'h81, 1'b0);
        @(negedge clk_in);
        rst_in = 1'b1;
        op_in = 8'd4; a_in = 8'hF0; b_in = 8'h20;
        @(posedge clk_in);
        #1;
        check_q_cleared("midreset");
        check("midreset comb result", 32'(result_out), 32'h10);
        @(negedge clk_in);
        rst_in = 1'b0;

        for (int i = 0; i < 300; i++) begin
            rop = 8'($urandom_range(0, 9));
            ra  = 8'($urandom_range(0, 255));
            rb  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 10))
                                               : 8'($urandom_range(0, 255));
            model(int'(rop), int'(ra), int'(rb), r, c);
            drive("random", rop, ra, rb, 8'(r), c[0]);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
